// File: rtl/player_collision_checker_if.sv
// Frame-start/player/obstacle inputs and crash/status outputs of the collision checker.
interface player_collision_checker_if #(
    parameter int unsigned NUM_OBJ = 8
);
    logic                          frame_start;
    logic [0:4][0:10]              player_state;
    logic [0:NUM_OBJ-1][0:4][0:10] obj_states;
    logic                          crash_pulse;
    logic [3:0]                    crash_obj_idx;
    logic                          invuln;
    logic                          scan_busy;
    logic                          overrun;

    modport master (
        output frame_start, player_state, obj_states,
        input  crash_pulse, crash_obj_idx, invuln, scan_busy, overrun
    );

    modport slave (
        input  frame_start, player_state, obj_states,
        output crash_pulse, crash_obj_idx, invuln, scan_busy, overrun
    );
endinterface

// File: rtl/player_collision_checker.sv
// Per-frame player/obstacle overlap scan, one slot per cycle, with post-crash cooldown.
module player_collision_checker #(
    parameter int unsigned NUM_OBJ         = 8,
    parameter int unsigned COOLDOWN_FRAMES = 192
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    player_collision_checker_if.slave bus_io
);

    localparam int unsigned IdxW  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int unsigned CoolW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_OBJ - 1);
    localparam logic [CoolW-1:0] CoolLoad = CoolW'(COOLDOWN_FRAMES);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StScan   = 2'd1;
    localparam logic [1:0] StReport = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             hit_q, hit_d;
    logic [IdxW-1:0]  hit_idx_q, hit_idx_d;
    logic             frame_invuln_q, frame_invuln_d;
    logic [CoolW-1:0] cool_q, cool_d;
    logic [3:0]       crash_idx_q, crash_idx_d;
    logic             overrun_q, overrun_d;
    logic [1:4][0:10] snap_q, snap_d;

    logic [0:4][0:10] obj;
    logic [11:0]      px, py, pw, ph, ox, oy, ow, oh;
    logic             slot_hit;
    logic             crash;
    logic             unused_img;

    // img_id of the player plays no part in the overlap test
    assign unused_img = ^bus_io.player_state[0];

    assign obj = bus_io.obj_states[idx_q];
    assign px  = {1'b0, snap_q[1]};
    assign py  = {1'b0, snap_q[2]};
    assign pw  = {1'b0, snap_q[3]};
    assign ph  = {1'b0, snap_q[4]};
    assign ox  = {1'b0, obj[1]};
    assign oy  = {1'b0, obj[2]};
    assign ow  = {1'b0, obj[3]};
    assign oh  = {1'b0, obj[4]};

    // 12-bit sums keep edges near 2047 from wrapping; strict compares reject touching edges
    assign slot_hit = (obj[0] != '0) && (px < ox + ow) && (ox < px + pw) &&
                      (py < oy + oh) && (oy < py + ph);

    assign crash = (state_q == StReport) && hit_q && !frame_invuln_q;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        hit_d          = hit_q;
        hit_idx_d      = hit_idx_q;
        frame_invuln_d = frame_invuln_q;
        cool_d         = cool_q;
        crash_idx_d    = crash_idx_q;
        overrun_d      = overrun_q;
        snap_d         = snap_q;

        if (bus_io.frame_start && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (bus_io.frame_start) begin
                    snap_d         = bus_io.player_state[1:4];
                    hit_d          = 1'b0;
                    idx_d          = '0;
                    frame_invuln_d = (cool_q != '0);
                    if (cool_q != '0) begin
                        cool_d = cool_q - 1'b1;
                    end
                    state_d = StScan;
                end
            end
            StScan: begin
                if (slot_hit && !hit_q) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                end
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StReport;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StReport: begin
                if (crash) begin
                    crash_idx_d = 4'(hit_idx_q);
                    cool_d      = CoolLoad;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            hit_q          <= 1'b0;
            hit_idx_q      <= '0;
            frame_invuln_q <= 1'b0;
            cool_q         <= '0;
            crash_idx_q    <= '0;
            overrun_q      <= 1'b0;
            snap_q         <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            hit_q          <= hit_d;
            hit_idx_q      <= hit_idx_d;
            frame_invuln_q <= frame_invuln_d;
            cool_q         <= cool_d;
            crash_idx_q    <= crash_idx_d;
            overrun_q      <= overrun_d;
            snap_q         <= snap_d;
        end
    end

    // The index is presented alongside the pulse, then held from the register
    assign bus_io.crash_pulse   = crash;
    assign bus_io.crash_obj_idx = crash ? 4'(hit_idx_q) : crash_idx_q;
    assign bus_io.invuln        = (cool_q != '0);
    assign bus_io.scan_busy     = (state_q != StIdle);
    assign bus_io.overrun       = overrun_q;

endmodule

// File: tb/tb_player_collision_checker.sv
// Directed and randomized bench for player_collision_checker against a frame-level model.
module tb_player_collision_checker;

    localparam int NumObj = 8;
    localparam int Cool   = 192;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    player_collision_checker_if #(.NUM_OBJ(NumObj)) bus ();

    player_collision_checker #(
        .NUM_OBJ        (NumObj),
        .COOLDOWN_FRAMES(Cool)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus_io (bus)
    );

    int total = 0;
    int bad = 0;
    int pulses = 0;
    bit chk_en = 1'b0;

    // Frame-level model: phase counts cycles since frame_start, result chosen at frame_start
    int m_phase = 0;
    int m_cool = 0;
    int m_first = -1;
    int m_idx = 0;
    bit m_finv = 1'b0;
    bit m_ovr = 1'b0;
    bit exp_pulse;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic int fld_p(int f);
        logic [10:0] v;
        v = bus.player_state[f];
        return int'(v);
    endfunction

    function automatic int fld_o(int k, int f);
        logic [10:0] v;
        v = bus.obj_states[k][f];
        return int'(v);
    endfunction

    function automatic int first_hit();
        int px, py, pw, ph;
        px = fld_p(1);
        py = fld_p(2);
        pw = fld_p(3);
        ph = fld_p(4);
        for (int k = 0; k < NumObj; k++) begin
            int oi, ox, oy, ow, oh;
            oi = fld_o(k, 0);
            ox = fld_o(k, 1);
            oy = fld_o(k, 2);
            ow = fld_o(k, 3);
            oh = fld_o(k, 4);
            if (oi != 0 && px < ox + ow && ox < px + pw && py < oy + oh && oy < py + ph) begin
                return k;
            end
        end
        return -1;
    endfunction

    function automatic int clamp11(int v);
        if (v < 0) return 0;
        if (v > 2047) return 2047;
        return v;
    endfunction

    task automatic set_player(int i, int x, int y, int w, int h);
        bus.player_state[0] = 11'(i);
        bus.player_state[1] = 11'(x);
        bus.player_state[2] = 11'(y);
        bus.player_state[3] = 11'(w);
        bus.player_state[4] = 11'(h);
    endtask

    task automatic set_obj(int k, int i, int x, int y, int w, int h);
        bus.obj_states[k][0] = 11'(i);
        bus.obj_states[k][1] = 11'(x);
        bus.obj_states[k][2] = 11'(y);
        bus.obj_states[k][3] = 11'(w);
        bus.obj_states[k][4] = 11'(h);
    endtask

    task automatic clear_objs();
        for (int k = 0; k < NumObj; k++) set_obj(k, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_player();
        int px, py;
        px = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1980, 2047))
                                         : int'($urandom_range(0, 2047));
        py = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1980, 2047))
                                         : int'($urandom_range(0, 2047));
        set_player(int'($urandom_range(0, 5)), px, py, int'($urandom_range(0, 70)),
                   int'($urandom_range(0, 70)));
    endtask

    task automatic rand_scene();
        int px, py, img;
        rand_player();
        px = fld_p(1);
        py = fld_p(2);
        for (int k = 0; k < NumObj; k++) begin
            img = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2047));
            set_obj(k, img, clamp11(px + int'($urandom_range(0, 160)) - 80),
                    clamp11(py + int'($urandom_range(0, 160)) - 80),
                    int'($urandom_range(0, 70)), int'($urandom_range(0, 70)));
        end
    endtask

    task automatic start_frame();
        bus.frame_start = 1'b1;
        cyc(1);
        bus.frame_start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_cool  <= 0;
            m_first <= -1;
            m_idx   <= 0;
            m_finv  <= 1'b0;
            m_ovr   <= 1'b0;
        end else begin
            if (bus.frame_start && m_phase != 0) m_ovr <= 1'b1;
            if (m_phase == 0) begin
                if (bus.frame_start) begin
                    m_phase <= 1;
                    m_finv  <= (m_cool != 0);
                    m_cool  <= (m_cool > 0) ? m_cool - 1 : 0;
                    m_first <= first_hit();
                end
            end else if (m_phase <= NumObj) begin
                m_phase <= m_phase + 1;
            end else begin
                if (m_first >= 0 && !m_finv) begin
                    m_cool <= Cool;
                    m_idx  <= m_first;
                end
                m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_pulse = (m_phase == NumObj + 1) && (m_first >= 0) && !m_finv;
            if (bus.crash_pulse) pulses++;
            chk("crash_pulse", int'(bus.crash_pulse), int'(exp_pulse));
            chk("scan_busy", int'(bus.scan_busy), int'(m_phase != 0));
            chk("invuln", int'(bus.invuln), int'(m_cool != 0));
            chk("overrun", int'(bus.overrun), int'(m_ovr));
            chk("crash_obj_idx", int'(bus.crash_obj_idx), exp_pulse ? m_first : m_idx);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, pfs, prst, pscr;
        bit rst0;
        bus.frame_start = 1'b0;
        set_player(0, 0, 0, 0, 0);
        clear_objs();
        reset = 1'b1;
        cyc(3);
        chk("rst_pulse", int'(bus.crash_pulse), 0);
        chk("rst_idx", int'(bus.crash_obj_idx), 0);
        chk("rst_invuln", int'(bus.invuln), 0);
        chk("rst_busy", int'(bus.scan_busy), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Basic overlap in slot 3
        set_player(0, 256, 380, 32, 36);
        set_obj(3, 5, 270, 390, 32, 36);
        start_frame();
        cyc(8);
        chk("ovl_pulse", int'(bus.crash_pulse), 1);
        chk("ovl_idx", int'(bus.crash_obj_idx), 3);
        cyc(1);
        chk("ovl_invuln", int'(bus.invuln), 1);
        chk("ovl_busy_end", int'(bus.scan_busy), 0);
        chk("ovl_idx_hold", int'(bus.crash_obj_idx), 3);
        cyc(2);

        // Touching right edge: 256+32 == 288
        do_reset();
        set_obj(3, 5, 288, 390, 32, 36);
        p0 = pulses;
        start_frame();
        cyc(8);
        chk("touch_busy_t9", int'(bus.scan_busy), 1);
        chk("touch_pulse", int'(bus.crash_pulse), 0);
        cyc(1);
        chk("touch_busy_t10", int'(bus.scan_busy), 0);
        cyc(2);
        chk("touch_npulse", pulses - p0, 0);

        // Lowest index wins, empty slot ignored
        do_reset();
        clear_objs();
        set_obj(1, 0, 256, 380, 32, 36);
        set_obj(2, 1, 250, 370, 20, 20);
        set_obj(5, 7, 280, 400, 10, 10);
        p0 = pulses;
        start_frame();
        cyc(8);
        chk("prio_pulse", int'(bus.crash_pulse), 1);
        chk("prio_idx", int'(bus.crash_obj_idx), 2);
        cyc(3);
        chk("prio_npulse", pulses - p0, 1);

        // Cooldown over persistent overlap
        p0 = pulses;
        repeat (Cool) begin
            start_frame();
            cyc(10);
        end
        chk("cool_quiet", pulses - p0, 0);
        chk("cool_invuln_off", int'(bus.invuln), 0);
        start_frame();
        cyc(8);
        chk("cool_repulse", int'(bus.crash_pulse), 1);
        chk("cool_idx", int'(bus.crash_obj_idx), 2);
        cyc(2);

        // Overrun: second frame_start at T+4 neither restarts nor extends
        do_reset();
        clear_objs();
        set_obj(3, 5, 270, 390, 32, 36);
        p0 = pulses;
        start_frame();
        cyc(3);
        bus.frame_start = 1'b1;
        cyc(1);
        bus.frame_start = 1'b0;
        chk("ovr_flag", int'(bus.overrun), 1);
        cyc(4);
        chk("ovr_pulse_t9", int'(bus.crash_pulse), 1);
        cyc(1);
        chk("ovr_busy_t10", int'(bus.scan_busy), 0);
        cyc(10);
        chk("ovr_npulse", pulses - p0, 1);
        chk("ovr_sticky", int'(bus.overrun), 1);

        // Reset mid-scan at T+5 aborts the frame
        do_reset();
        p0 = pulses;
        start_frame();
        cyc(2);
        bus.frame_start = 1'b1;
        cyc(1);
        bus.frame_start = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("abort_pulse", int'(bus.crash_pulse), 0);
        chk("abort_idx", int'(bus.crash_obj_idx), 0);
        chk("abort_invuln", int'(bus.invuln), 0);
        chk("abort_busy", int'(bus.scan_busy), 0);
        chk("abort_overrun", int'(bus.overrun), 0);
        cyc(10);
        chk("abort_npulse", pulses - p0, 0);

        // Reset beats a simultaneous frame_start
        reset = 1'b1;
        bus.frame_start = 1'b1;
        cyc(1);
        reset = 1'b0;
        bus.frame_start = 1'b0;
        chk("rstprio_busy", int'(bus.scan_busy), 0);
        cyc(2);

        // Randomized frames with mid-scan player changes, overruns and resets
        repeat (400) begin
            rand_scene();
            rst0 = ($urandom_range(0, 29) == 0);
            pfs  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 9)) : 0;
            prst = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 10)) : 0;
            pscr = int'($urandom_range(1, 9));
            if (rst0 || (prst != 0 && pfs >= prst)) pfs = 0;
            reset = rst0;
            bus.frame_start = 1'b1;
            cyc(1);
            bus.frame_start = 1'b0;
            reset = 1'b0;
            for (int j = 1; j <= 10; j++) begin
                if (j == pscr) rand_player();
                bus.frame_start = (j == pfs);
                reset = (j == prst);
                cyc(1);
            end
            bus.frame_start = 1'b0;
            reset = 1'b0;
            cyc(int'($urandom_range(0, 2)));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_collision_checker.md
PLAYER_COLLISION_CHECKER -- requirements
Module: player_collision_checker

Interface
REQ-001 Parameter NUM_OBJ, default 8: number of obstacle slots scanned per frame, range 2..16.
REQ-002 Parameter COOLDOWN_FRAMES, default 192: frames of invulnerability after a crash, matching the player death animation length.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle pulse at the start of each video frame.
REQ-006 player_state  input  [0:4][0:10]  player record {img_id, x, y, width, height}, the output of the player controller.
REQ-007 obj_states  input  [0:NUM_OBJ-1][0:4][0:10]  obstacle records in the same field order; img_id==0 marks an empty slot.
REQ-008 crash_pulse  output  1  one-cycle pulse when a collision is detected for the current frame.
REQ-009 crash_obj_idx  output  4  slot index of the reported collision; holds its value until the next crash.
REQ-010 invuln  output  1  high while the cooldown counter is non-zero.
REQ-011 scan_busy  output  1  high while in SCAN or REPORT.
REQ-012 overrun  output  1  sticky flag: a frame_start arrived while scan_busy was high.

Function
REQ-013 The FSM SHALL have three states: IDLE, SCAN and REPORT.
REQ-014 In IDLE, frame_start SHALL latch player_state into a snapshot, clear the hit flag, set idx=0, latch frame_invuln=(cooldown!=0), and move to SCAN.
REQ-015 On the same frame_start edge, cooldown SHALL decrement by 1 if it is non-zero, with no underflow below 0.
REQ-016 SCAN SHALL test exactly one slot per cycle, obj_states[idx], against the snapshot, then increment idx.
REQ-017 After testing idx==NUM_OBJ-1, SCAN SHALL move to REPORT.
REQ-018 A slot hits when all of the following hold: img_id!=0; px<ox+ow; ox<px+pw; py<oy+oh; oy<py+ph.
REQ-019 All comparisons SHALL use strict inequality, so touching edges are not a hit.
REQ-020 Sums SHALL be computed at 12 bits, so no wrap occurs at 11-bit overflow.
REQ-021 The first hit SHALL record idx and set the hit flag; later hits in the same scan SHALL be ignored, so the lowest index wins.
REQ-022 REPORT SHALL last one cycle: if hit && !frame_invuln, assert crash_pulse, load crash_obj_idx, and set cooldown=COOLDOWN_FRAMES; in all cases, return to IDLE.
REQ-023 Latency: frame_start at cycle T gives scans at T+1..T+NUM_OBJ and crash_pulse at T+NUM_OBJ+1; scan_busy is high from T+1 through T+NUM_OBJ+1 inclusive.
REQ-024 frame_start while scan_busy is high SHALL NOT restart or extend the scan, SHALL NOT decrement cooldown, and SHALL set overrun.
REQ-025 overrun SHALL be cleared only by reset.
REQ-026 obj_states SHALL be sampled live during SCAN; upstream holds it stable between frame_start pulses.
REQ-027 player_state SHALL be used only through the snapshot taken at frame_start.
REQ-028 crash_pulse SHALL NOT assert in any cycle other than REPORT.
REQ-029 crash_pulse SHALL NOT assert on two consecutive frames, because the cooldown load suppresses it.
REQ-030 invuln SHALL be combinational from cooldown and visible the cycle after the cooldown load.

Reset
REQ-031 reset SHALL force the following: state=IDLE, idx=0, hit=0, cooldown=0, crash_pulse=0, crash_obj_idx=0, invuln=0, scan_busy=0, overrun=0.
REQ-032 reset asserted mid-SCAN or in REPORT SHALL abort the scan with no crash_pulse.
REQ-033 reset SHALL take priority over a simultaneous frame_start.

Verification
REQ-034 Overlap. Setup: NUM_OBJ=8; player {0,256,380,32,36}; slot3={5,270,390,32,36}; other slots empty; frame_start at T. Required: crash_pulse at T+9, crash_obj_idx=3, invuln=1 at T+10.
REQ-035 Touching edge. Setup: slot3 x=288, other fields as in REQ-034. Required: no crash_pulse; scan_busy falls after T+9.
REQ-036 Priority and empty slot. Setup: hits in slots 2 and 5; slot 1 overlapping with img_id=0. Required: crash_obj_idx=2, one pulse.
REQ-037 Cooldown. Setup: persistent overlap; first crash on frame F. Required: no crash_pulse on frames F+1..F+192; crash_pulse on frame F+193.
REQ-038 Overrun and reset. Setup: second frame_start at T+4. Required: overrun=1, crash_pulse still at T+9 only. Setup: reset at T+5. Required: no pulse; all outputs 0 at T+6.
